param_mod_counter_bcd: RTL



---
 rtl/param_mod_counter_bcd.sv | 139 +++++++++++++
 1 files changed

// File: rtl/param_mod_counter_bcd.sv
// Loadable up/down modulo counter with a sequential shift-and-add-3 BCD converter.
// The BCD output only changes when a whole conversion completes.
module param_mod_counter_bcd #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256,
    parameter int DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      d,
    output logic [WIDTH-1:0]      q,
    output logic                  wrap,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy
);

    // state   | meaning
    // S_IDLE  | bcd matches last_conv; start a conversion when q differs
    // S_SHIFT | converting snap, one bit per clock, WIDTH clocks total
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam int               SW   = 4*DIGITS + WIDTH;
    localparam int               CW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "MODULUS must lie in 2..2**WIDTH");
    end
    if (pow10(DIGITS) < longint'(MODULUS)) begin : g_bad_digits
        $fatal(1, "DIGITS too small to represent MODULUS-1");
    end

    logic [WIDTH-1:0]    r_q;
    logic                r_wrap;
    logic [4*DIGITS-1:0] r_bcd;
    logic [WIDTH-1:0]    r_last_conv;
    logic [WIDTH-1:0]    r_snap;
    logic [SW-1:0]       r_sr;
    logic [CW-1:0]       r_bit_cnt;
    state_t              r_state;
    state_t              w_next;
    logic [SW-1:0]       w_adj;
    logic [SW-1:0]       w_shifted;
    logic                w_last_bit;
    logic                w_differs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= (d > MAXV) ? MAXV : d;
            r_wrap <= 1'b0;
        end else if (en) begin
            if (up) begin
                r_q    <= (r_q == MAXV) ? '0 : r_q + 1'b1;
                r_wrap <= (r_q == MAXV);
            end else begin
                r_q    <= (r_q == '0) ? MAXV : r_q - 1'b1;
                r_wrap <= (r_q == '0);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign w_differs  = (r_q != r_last_conv);
    assign w_last_bit = (r_bit_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_sr[WIDTH + 4*i +: 4] >= 4'd5)
                w_adj[WIDTH + 4*i +: 4] = r_sr[WIDTH + 4*i +: 4] + 4'd3;
        end
    end

    assign w_shifted = w_adj << 1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_differs)  w_next = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_bcd       <= '0;
            r_last_conv <= '0;
            r_snap      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_differs) begin
                        r_snap    <= r_q;
                        r_sr      <= {{(4*DIGITS){1'b0}}, r_q};
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_sr      <= w_shifted;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_bcd       <= w_shifted[SW-1 -: 4*DIGITS];
                        r_last_conv <= r_snap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q         = r_q;
    assign wrap      = r_wrap;
    assign bcd       = r_bcd;
    assign busy      = (r_state == S_SHIFT);
    assign bcd_valid = (r_state == S_IDLE) && !w_differs;

endmodule
